// File: rtl/memctl_refill_rsp_pkg.sv
// Shared types for the memory-controller linefill response path.
//   - mem_op_e               : memory op encodings (only LOAD reaches this block)
//   - memctl_tracker_state_e : per-entry fill tracker state
//   - memctl_entry_t         : tracker entry payload {state, id, addr, beat_cnt}
//   - memctl_line_align()    : clears the line-offset bits of an address
package memctl_refill_rsp_pkg;

  localparam int unsigned MEMCTL_ID_W   = 8;
  localparam int unsigned MEMCTL_ADDR_W = 32;
  localparam int unsigned MEMCTL_BEATS  = 4;
  localparam int unsigned MEMCTL_OFF_W  = $clog2(MEMCTL_BEATS);
  localparam int unsigned MEM_OP_W      = 3;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NONE  = 3'd0,
    MEM_OP_LOAD  = 3'd1,
    MEM_OP_STORE = 3'd2,
    MEM_OP_EVICT = 3'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    MT_FREE   = 2'd0,
    MT_PEND   = 2'd1,
    MT_ISSUED = 2'd2,
    MT_FILL   = 2'd3
  } memctl_tracker_state_e;

  typedef struct packed {
    memctl_tracker_state_e     state;
    logic [MEMCTL_ID_W-1:0]    id;
    logic [MEMCTL_ADDR_W-1:0]  addr;
    logic [MEMCTL_OFF_W-1:0]   beat_cnt;
  } memctl_entry_t;

  // Clear the low lsb bits so the address points at the start of its line.
  function automatic logic [MEMCTL_ADDR_W-1:0] memctl_line_align(
    input logic [MEMCTL_ADDR_W-1:0] addr,
    input int unsigned              lsb
  );
    logic [MEMCTL_ADDR_W-1:0] mask;
    mask = ~((MEMCTL_ADDR_W'(1) << lsb) - MEMCTL_ADDR_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/memctl_idx_fifo.sv
// FIFO of tracker indices that orders read-address issue by allocation order.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : tracker index
//   pop        : drop the head entry (only when non-empty)
//   head_c     : current head index (combinational read)
//   empty_c    : no index queued (combinational)
// Push and pop in the same cycle are allowed; the owner guarantees no overflow.
module memctl_idx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_c,
  output logic         empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     mem_q [DEPTH];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign empty_c = (cnt_q == '0);

endmodule

// File: rtl/memctl_refill_rsp.sv
// Memory-controller end of the linefill interface.
// Accepts LOAD linefill requests, tracks up to OST outstanding fills, issues
// line-aligned burst reads in allocation order and returns each line
// beat-by-beat to the refill writer tagged with the requesting nline id.
//   clk, rst          : clock, synchronous active-high reset
//   u_memctl_*        : linefill request {op, id, addr}, valid/ready
//   m_ar_*            : bus read address {addr, tag}, valid/ready
//   m_r_*             : bus read data {tag, data, last, err}, valid/ready
//   d_refill_*        : refill beat {id, offset, data, last, err}, valid/ready
//   err_unexp         : sticky, a beat arrived for a FREE/PEND tracker
module memctl_refill_rsp
  import memctl_refill_rsp_pkg::*;
#(
  parameter int unsigned ID_W   = MEMCTL_ID_W,
  parameter int unsigned ADDR_W = MEMCTL_ADDR_W,
  parameter int unsigned BEAT_W = 32,
  parameter int unsigned BEATS  = MEMCTL_BEATS,
  parameter int unsigned OST    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     u_memctl_valid,
  output logic                     u_memctl_ready,
  input  logic [2:0]               u_memctl_op,
  input  logic [ID_W-1:0]          u_memctl_id,
  input  logic [ADDR_W-1:0]        u_memctl_addr,
  output logic                     m_ar_valid,
  input  logic                     m_ar_ready,
  output logic [ADDR_W-1:0]        m_ar_addr,
  output logic [$clog2(OST)-1:0]   m_ar_tag,
  input  logic                     m_r_valid,
  output logic                     m_r_ready,
  input  logic [$clog2(OST)-1:0]   m_r_tag,
  input  logic [BEAT_W-1:0]        m_r_data,
  input  logic                     m_r_last,
  input  logic                     m_r_err,
  output logic                     d_refill_valid,
  input  logic                     d_refill_ready,
  output logic [ID_W-1:0]          d_refill_id,
  output logic [$clog2(BEATS)-1:0] d_refill_offset,
  output logic [BEAT_W-1:0]        d_refill_data,
  output logic                     d_refill_last,
  output logic                     d_refill_err,
  output logic                     err_unexp
);

  localparam int unsigned TAG_W    = $clog2(OST);
  localparam int unsigned OFF_W    = $clog2(BEATS);
  localparam int unsigned LINE_LSB = $clog2(BEATS * BEAT_W / 8);

  localparam memctl_entry_t ENT_RST = '{state: MT_FREE, id: '0, addr: '0, beat_cnt: '0};

  // The tracker entry type is sized by the package; reject mismatched overrides.
  if (ID_W != MEMCTL_ID_W || ADDR_W != MEMCTL_ADDR_W || BEATS != MEMCTL_BEATS ||
      BEATS < 2 || OST < 2 || (OST & (OST - 1)) != 0) begin : g_param_chk
    $error("memctl_refill_rsp: unsupported parameter set");
  end

  memctl_entry_t    ent_q [OST];
  memctl_entry_t    ent_d [OST];
  logic [OST-1:0]   free_vec;
  logic [TAG_W-1:0] alloc_idx;
  logic [TAG_W-1:0] fifo_head;
  logic             fifo_empty;
  logic             u_hsk;
  logic             ar_hsk;
  logic             r_hsk;
  memctl_entry_t    r_ent;
  logic             r_live;
  logic             exp_last;
  logic             fwd;

  // Free-entry vector and lowest-free priority encode.
  always_comb begin
    free_vec  = '0;
    alloc_idx = '0;
    for (int i = 0; i < int'(OST); i++) begin
      free_vec[i] = (ent_q[i].state == MT_FREE);
    end
    for (int i = int'(OST) - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = TAG_W'(i);
    end
  end

  assign u_memctl_ready = |free_vec;
  assign u_hsk          = u_memctl_valid & u_memctl_ready;

  memctl_idx_fifo #(
    .DEPTH (OST),
    .W     (TAG_W)
  ) u_idx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (u_hsk),
    .push_data (alloc_idx),
    .pop       (ar_hsk),
    .head_c    (fifo_head),
    .empty_c   (fifo_empty)
  );

  // Read address comes straight from the queued head entry, so it stays put
  // until the bus accepts it.
  assign m_ar_valid = !fifo_empty;
  assign m_ar_tag   = fifo_head;
  assign m_ar_addr  = ADDR_W'(ent_q[fifo_head].addr);
  assign ar_hsk     = m_ar_valid & m_ar_ready;

  // Beats are accepted whenever the one-deep output register can take one.
  assign m_r_ready = !d_refill_valid | d_refill_ready;
  assign r_hsk     = m_r_valid & m_r_ready;
  assign r_ent     = ent_q[m_r_tag];
  assign r_live    = (r_ent.state == MT_ISSUED) || (r_ent.state == MT_FILL);
  assign exp_last  = (r_ent.beat_cnt == MEMCTL_OFF_W'(BEATS - 1));
  assign fwd       = r_hsk & r_live;

  // Tracker next-state: alloc, issue and beat return touch disjoint entries.
  always_comb begin
    for (int i = 0; i < int'(OST); i++) begin
      ent_d[i] = ent_q[i];
    end
    if (u_hsk) begin
      ent_d[alloc_idx].state    = MT_PEND;
      ent_d[alloc_idx].id       = MEMCTL_ID_W'(u_memctl_id);
      ent_d[alloc_idx].addr     = memctl_line_align(MEMCTL_ADDR_W'(u_memctl_addr), LINE_LSB);
      ent_d[alloc_idx].beat_cnt = '0;
    end
    if (ar_hsk) begin
      ent_d[fifo_head].state = MT_ISSUED;
    end
    // Either an early last or the final expected beat retires the entry.
    if (fwd) begin
      if (m_r_last || exp_last) begin
        ent_d[m_r_tag].state    = MT_FREE;
        ent_d[m_r_tag].beat_cnt = '0;
      end else begin
        ent_d[m_r_tag].state    = MT_FILL;
        ent_d[m_r_tag].beat_cnt = r_ent.beat_cnt + MEMCTL_OFF_W'(1);
      end
    end
  end

  // Tracker state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(OST); i++) ent_q[i] <= ENT_RST;
    end else begin
      for (int i = 0; i < int'(OST); i++) ent_q[i] <= ent_d[i];
    end
  end

  // Output valid and sticky unexpected-beat flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_refill_valid <= 1'b0;
      err_unexp      <= 1'b0;
    end else begin
      if (fwd) begin
        d_refill_valid <= 1'b1;
      end else if (d_refill_ready) begin
        d_refill_valid <= 1'b0;
      end
      if (r_hsk && !r_live) err_unexp <= 1'b1;
    end
  end

  // Output payload; a length mismatch in either direction marks the beat bad.
  always_ff @(posedge clk) begin
    if (fwd) begin
      d_refill_id     <= ID_W'(r_ent.id);
      d_refill_offset <= OFF_W'(r_ent.beat_cnt);
      d_refill_data   <= m_r_data;
      d_refill_last   <= exp_last;
      d_refill_err    <= m_r_err | (m_r_last != exp_last);
    end
  end

`ifndef SYNTHESIS
  logic id_dup_c;

  // An id may only be outstanding once.
  always_comb begin
    id_dup_c = 1'b0;
    for (int i = 0; i < int'(OST); i++) begin
      if (ent_q[i].state != MT_FREE && ent_q[i].id == MEMCTL_ID_W'(u_memctl_id)) id_dup_c = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst && u_hsk) begin
      assert (u_memctl_op == 3'(MEM_OP_LOAD));
      assert (!id_dup_c);
    end
  end
`endif

endmodule

// File: tb/tb_memctl_refill_rsp.sv
module tb_memctl_refill_rsp;
  import memctl_refill_rsp_pkg::*;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BEAT_W = 32;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned OST    = 4;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned OFF_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              u_memctl_valid;
  logic              u_memctl_ready;
  logic [2:0]        u_memctl_op;
  logic [ID_W-1:0]   u_memctl_id;
  logic [ADDR_W-1:0] u_memctl_addr;
  logic              m_ar_valid;
  logic              m_ar_ready;
  logic [ADDR_W-1:0] m_ar_addr;
  logic [TAG_W-1:0]  m_ar_tag;
  logic              m_r_valid;
  logic              m_r_ready;
  logic [TAG_W-1:0]  m_r_tag;
  logic [BEAT_W-1:0] m_r_data;
  logic              m_r_last;
  logic              m_r_err;
  logic              d_refill_valid;
  logic              d_refill_ready;
  logic [ID_W-1:0]   d_refill_id;
  logic [OFF_W-1:0]  d_refill_offset;
  logic [BEAT_W-1:0] d_refill_data;
  logic              d_refill_last;
  logic              d_refill_err;
  logic              err_unexp;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  memctl_refill_rsp #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .OST(OST)
  ) dut (
    .clk(clk), .rst(rst),
    .u_memctl_valid(u_memctl_valid), .u_memctl_ready(u_memctl_ready),
    .u_memctl_op(u_memctl_op), .u_memctl_id(u_memctl_id), .u_memctl_addr(u_memctl_addr),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_tag(m_ar_tag),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_tag(m_r_tag), .m_r_data(m_r_data),
    .m_r_last(m_r_last), .m_r_err(m_r_err),
    .d_refill_valid(d_refill_valid), .d_refill_ready(d_refill_ready), .d_refill_id(d_refill_id),
    .d_refill_offset(d_refill_offset), .d_refill_data(d_refill_data),
    .d_refill_last(d_refill_last), .d_refill_err(d_refill_err),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // All tasks start and end one time unit after a rising edge.
  task automatic send_req(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr);
    int unsigned w = 0;
    u_memctl_valid = 1'b1;
    u_memctl_op    = 3'(MEM_OP_LOAD);
    u_memctl_id    = id;
    u_memctl_addr  = addr;
    #1;
    while (!u_memctl_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check_val("req_ready", u_memctl_ready, 1);
    @(posedge clk); #1;
    u_memctl_valid = 1'b0;
  endtask

  task automatic accept_ar(input logic [ADDR_W-1:0] exp_addr, input logic [TAG_W-1:0] exp_tag);
    int unsigned w = 0;
    m_ar_ready = 1'b1;
    #1;
    while (!m_ar_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check_val("ar_valid", m_ar_valid, 1);
    check_val("ar_addr", m_ar_addr, exp_addr);
    check_val("ar_tag", m_ar_tag, exp_tag);
    @(posedge clk); #1;
    m_ar_ready = 1'b0;
  endtask

  task automatic send_beat(input logic [TAG_W-1:0] tag, input logic [BEAT_W-1:0] data,
                           input logic last, input logic err);
    int unsigned w = 0;
    m_r_valid = 1'b1;
    m_r_tag   = tag;
    m_r_data  = data;
    m_r_last  = last;
    m_r_err   = err;
    #1;
    while (!m_r_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check_val("r_ready", m_r_ready, 1);
    @(posedge clk); #1;
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
    m_r_err   = 1'b0;
  endtask

  task automatic check_out(input string pfx, input logic [ID_W-1:0] id, input logic [OFF_W-1:0] off,
                           input logic [BEAT_W-1:0] data, input logic last, input logic err);
    check_val({pfx, "_valid"}, d_refill_valid, 1);
    check_val({pfx, "_id"}, d_refill_id, id);
    check_val({pfx, "_off"}, d_refill_offset, off);
    check_val({pfx, "_data"}, d_refill_data, data);
    check_val({pfx, "_last"}, d_refill_last, last);
    check_val({pfx, "_err"}, d_refill_err, err);
  endtask

  initial begin
    rst = 1'b1;
    u_memctl_valid = 1'b0; u_memctl_op = 3'(MEM_OP_LOAD); u_memctl_id = '0; u_memctl_addr = '0;
    m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_tag = '0; m_r_data = '0; m_r_last = 1'b0; m_r_err = 1'b0;
    d_refill_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_refill_valid", d_refill_valid, 0);
    check_val("rst_ar_valid", m_ar_valid, 0);
    check_val("rst_u_ready", u_memctl_ready, 1);
    check_val("rst_err_unexp", err_unexp, 0);
    check_val("rst_r_ready", m_r_ready, 1);
    rst = 1'b0;

    // Single fill.
    send_req(8'h25, 32'h0000_1234);
    accept_ar(32'h0000_1230, 2'd0);
    for (int i = 0; i < 4; i++) begin
      send_beat(2'd0, 32'hD000_0000 + 32'(i), (i == 3), 1'b0);
      check_out("single", 8'h25, OFF_W'(i), 32'hD000_0000 + 32'(i), (i == 3), 1'b0);
    end
    @(posedge clk); #1;
    check_val("single_drain", d_refill_valid, 0);

    // Fill all trackers, fifth request stalls until tag 2 completes.
    for (int i = 0; i < 4; i++) send_req(8'h10 + 8'(i), 32'h100 * (32'(i) + 1) + 32'h8);
    for (int i = 0; i < 4; i++) accept_ar(32'h100 * (32'(i) + 1), TAG_W'(i));
    u_memctl_valid = 1'b1;
    u_memctl_id    = 8'h14;
    u_memctl_addr  = 32'h0000_050C;
    #1;
    check_val("full_ready", u_memctl_ready, 0);
    for (int i = 0; i < 4; i++) begin
      send_beat(2'd2, 32'hA200_0000 + 32'(i), (i == 3), 1'b0);
      check_out("tag2", 8'h12, OFF_W'(i), 32'hA200_0000 + 32'(i), (i == 3), 1'b0);
    end
    check_val("freed_ready", u_memctl_ready, 1);
    @(posedge clk); #1;
    u_memctl_valid = 1'b0;
    check_val("refull_ready", u_memctl_ready, 0);
    accept_ar(32'h0000_0500, 2'd2);

    // Interleaved beats across tags 1 and 0.
    send_beat(2'd1, 32'hB100_0000, 1'b0, 1'b0);
    check_out("il0", 8'h11, 2'd0, 32'hB100_0000, 1'b0, 1'b0);
    send_beat(2'd0, 32'hB000_0000, 1'b0, 1'b0);
    check_out("il1", 8'h10, 2'd0, 32'hB000_0000, 1'b0, 1'b0);
    send_beat(2'd1, 32'hB100_0001, 1'b0, 1'b0);
    check_out("il2", 8'h11, 2'd1, 32'hB100_0001, 1'b0, 1'b0);
    send_beat(2'd0, 32'hB000_0001, 1'b0, 1'b0);
    check_out("il3", 8'h10, 2'd1, 32'hB000_0001, 1'b0, 1'b0);
    send_beat(2'd1, 32'hB100_0002, 1'b0, 1'b0);
    send_beat(2'd1, 32'hB100_0003, 1'b1, 1'b0);
    check_out("il1_end", 8'h11, 2'd3, 32'hB100_0003, 1'b1, 1'b0);
    send_beat(2'd0, 32'hB000_0002, 1'b0, 1'b0);
    send_beat(2'd0, 32'hB000_0003, 1'b1, 1'b0);
    check_out("il0_end", 8'h10, 2'd3, 32'hB000_0003, 1'b1, 1'b0);

    // Refill back-pressure mid-burst on tag 2.
    send_beat(2'd2, 32'hC000_0000, 1'b0, 1'b0);
    check_out("stall0", 8'h14, 2'd0, 32'hC000_0000, 1'b0, 1'b0);
    d_refill_ready = 1'b0;
    m_r_valid = 1'b1; m_r_tag = 2'd2; m_r_data = 32'hC000_0001; m_r_last = 1'b0; m_r_err = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_val("stall_r_ready", m_r_ready, 0);
      check_val("stall_hold", d_refill_data, 32'hC000_0000);
      @(posedge clk); #1;
    end
    d_refill_ready = 1'b1;
    #1;
    check_val("unstall_r_ready", m_r_ready, 1);
    @(posedge clk); #1;
    m_r_valid = 1'b0;
    check_out("stall1", 8'h14, 2'd1, 32'hC000_0001, 1'b0, 1'b0);
    send_beat(2'd2, 32'hC000_0002, 1'b0, 1'b0);
    send_beat(2'd2, 32'hC000_0003, 1'b1, 1'b0);
    check_out("stall3", 8'h14, 2'd3, 32'hC000_0003, 1'b1, 1'b0);

    // Early last on tag 3, then a beat on the freed tag.
    send_beat(2'd3, 32'hE300_0000, 1'b0, 1'b0);
    check_out("early0", 8'h13, 2'd0, 32'hE300_0000, 1'b0, 1'b0);
    send_beat(2'd3, 32'hE300_0001, 1'b1, 1'b0);
    check_out("early1", 8'h13, 2'd1, 32'hE300_0001, 1'b0, 1'b1);
    check_val("pre_unexp", err_unexp, 0);
    send_beat(2'd3, 32'hE300_0002, 1'b0, 1'b0);
    check_val("unexp_no_fwd", d_refill_valid, 0);
    check_val("unexp_flag", err_unexp, 1);
    @(posedge clk); #1;
    check_val("unexp_sticky", err_unexp, 1);

    // Reset during FILL with a read address pending.
    send_req(8'h30, 32'h0000_2004);
    accept_ar(32'h0000_2000, 2'd0);
    send_req(8'h31, 32'h0000_3000);
    send_beat(2'd0, 32'hF000_0000, 1'b0, 1'b0);
    check_out("prerst", 8'h30, 2'd0, 32'hF000_0000, 1'b0, 1'b0);
    check_val("prerst_ar_valid", m_ar_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("postrst_refill_valid", d_refill_valid, 0);
    check_val("postrst_ar_valid", m_ar_valid, 0);
    check_val("postrst_u_ready", u_memctl_ready, 1);
    check_val("postrst_err_unexp", err_unexp, 0);
    send_beat(2'd0, 32'hF000_0001, 1'b0, 1'b0);
    check_val("stale_no_fwd", d_refill_valid, 0);
    check_val("stale_unexp", err_unexp, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
